count_disp_n: RTL

- Parametrised successor to the fixed 16-bit hex counter / 4-digit display path.
- Single block containing:
  - a tick prescaler;
  - an NDIG-digit up/down counter with hex or BCD mode, synchronous load and wrap flag;
  - a time-multiplexed 7-segment scanner with leading-zero blanking.
- Drives the board's common-anode display and exposes the count for LEDs and other logic.

---
 rtl/count_disp_n.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/count_disp_n.sv
// count_disp_n: tick prescaler, NDIG-digit hex/BCD up/down counter with load
// and wrap flag, and a multiplexed common-anode 7-segment scanner with
// leading-zero blanking. All outputs are registered.
module count_disp_n #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 25000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              dir,
  input  logic              bcd_mode,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              blank_lz,
  output logic [4*NDIG-1:0] count,
  output logic              wrap,
  output logic              tick,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int W  = 4 * NDIG;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [TW-1:0]   r_pre;
  logic            r_tick;
  logic [W-1:0]    r_count;
  logic            r_wrap;
  logic [SW-1:0]   r_scan;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_seg;
  logic [NDIG-1:0] r_an;

  logic [W-1:0]    w_load_clamped;
  logic [W-1:0]    w_next;
  logic            w_next_wrap;
  logic            w_cy;
  logic [3:0]      w_d;
  logic [3:0]      w_digit;
  logic            w_upper_zero;
  logic            w_blank;
  logic [6:0]      w_glyph;

  // Prescaler: free-running 0..TICK_DIV-1, tick registered on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pre == TICK_LAST);
      r_pre  <= (r_pre == TICK_LAST) ? '0 : r_pre + TW'(1);
    end
  end

  // Next-count logic: clamped load value and one step in hex or BCD.
  always_comb begin
    w_load_clamped = load_val;
    w_next         = r_count;
    w_next_wrap    = 1'b0;
    w_cy           = 1'b1;
    w_d            = 4'd0;
    if (bcd_mode) begin
      for (int i = 0; i < NDIG; i++) begin
        if (load_val[4*i +: 4] > 4'd9) w_load_clamped[4*i +: 4] = 4'd9;
      end
    end
    if (!bcd_mode) begin
      if (dir) begin
        w_next      = r_count + W'(1);
        w_next_wrap = &r_count;
      end else begin
        w_next      = r_count - W'(1);
        w_next_wrap = ~|r_count;
      end
    end else begin
      // Ripple carry (up) or borrow (down) from digit 0; a digit above 9
      // going down snaps to 9 and absorbs the borrow.
      for (int i = 0; i < NDIG; i++) begin
        w_d = r_count[4*i +: 4];
        if (w_cy) begin
          if (dir) begin
            if (w_d >= 4'd9) begin
              w_next[4*i +: 4] = 4'd0;
            end else begin
              w_next[4*i +: 4] = w_d + 4'd1;
              w_cy             = 1'b0;
            end
          end else begin
            if (w_d == 4'd0) begin
              w_next[4*i +: 4] = 4'd9;
            end else if (w_d > 4'd9) begin
              w_next[4*i +: 4] = 4'd9;
              w_cy             = 1'b0;
            end else begin
              w_next[4*i +: 4] = w_d - 4'd1;
              w_cy             = 1'b0;
            end
          end
        end
      end
      w_next_wrap = w_cy;
    end
  end

  // Counter register: load beats a step; wrap only pulses on a wrapping step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
    end else if (r_tick && run) begin
      r_count <= w_next;
      r_wrap  <= w_next_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Scanner: dwell SCAN_DIV cycles per digit, index cycles 0..NDIG-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_scan <= r_scan + SW'(1);
    end
  end

  // Digit select, leading-zero detection and glyph lookup for the current index.
  always_comb begin
    w_digit      = 4'd0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == r_idx) w_digit = r_count[4*i +: 4];
      if ((IW'(i) >= r_idx) && (r_count[4*i +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_blank = blank_lz && (r_idx != '0) && w_upper_zero;
    case (w_digit)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      default: w_glyph = 7'h71;
    endcase
  end

  // Display registers: active-low anode and segments, decimal point off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 8'hFF;
      r_an  <= '1;
    end else begin
      r_an  <= ~(NDIG'(1) << r_idx);
      r_seg <= w_blank ? 8'hFF : {1'b1, ~w_glyph};
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tick  = r_tick;
  assign seg   = r_seg;
  assign an    = r_an;

endmodule
